// File: rtl/prng_arbiter.sv
// Round-robin burst arbiter that shares one PRNG byte stream through a small FIFO,
// freezing the PRNG while the FIFO is full. Optional counters under PRNG_ARB_STATS_EN.
`timescale 1ns/1ps
module prng_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic [7:0]         prng_dout,
    input  logic               prng_done,
    output logic               prng_hold,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [7:0]         rnd_data,
    output logic               rnd_valid,
    output logic               rnd_last
`ifdef PRNG_ARB_STATS_EN
    ,
    output logic [15:0]        drop_cnt,
    output logic [7:0]         abort_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [7:0]         burst_q, burst_d;
    logic [7:0]         rnd_data_q, rnd_data_d;
    logic               rnd_valid_q, rnd_valid_d;
    logic               rnd_last_q, rnd_last_d;
    logic               prng_hold_q, prng_hold_d;
    logic               done_prev_q;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic capture, full, empty, pop, push_ok;

    // First set request strictly after the last winner, wrapping around.
    function automatic logic [PW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [PW-1:0] last);
        logic [PW-1:0] win;
        logic          found;
        int            idx;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && r[idx]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign capture = prng_done & ~done_prev_q;
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = capture & (~full | pop);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        ptr_d       = ptr_q;
        burst_d     = burst_q;
        rnd_data_d  = rnd_data_q;
        rnd_valid_d = 1'b0;
        rnd_last_d  = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (|req) begin
                    ptr_d   = rr_pick(req, ptr_q);
                    gnt_d   = NUM_REQ'(1) << ptr_d;
                    burst_d = '0;
                    state_d = SERVE;
                end
            end
            SERVE: begin
                if (!req[ptr_q]) begin
                    gnt_d   = '0;
                    burst_d = '0;
                    state_d = IDLE;
                end else if (!empty) begin
                    pop         = 1'b1;
                    rnd_data_d  = mem_q[rd_ptr_q];
                    rnd_valid_d = 1'b1;
                    burst_d     = burst_q + 8'd1;
                    if (burst_q + 8'd1 == 8'(BURST_LEN)) begin
                        rnd_last_d = 1'b1;
                        gnt_d      = '0;
                        state_d    = IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + AW'(push_ok);
        rd_ptr_d    = rd_ptr_q + AW'(pop);
        count_d     = count_q + CW'(push_ok) - CW'(pop);
        prng_hold_d = (count_d == CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            ptr_q       <= PW'(NUM_REQ - 1);
            burst_q     <= '0;
            rnd_data_q  <= '0;
            rnd_valid_q <= 1'b0;
            rnd_last_q  <= 1'b0;
            prng_hold_q <= 1'b1;
            done_prev_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            ptr_q       <= ptr_d;
            burst_q     <= burst_d;
            rnd_data_q  <= rnd_data_d;
            rnd_valid_q <= rnd_valid_d;
            rnd_last_q  <= rnd_last_d;
            prng_hold_q <= prng_hold_d;
            done_prev_q <= prng_done;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= prng_dout;
        end
    end

    assign gnt       = gnt_q;
    assign rnd_data  = rnd_data_q;
    assign rnd_valid = rnd_valid_q;
    assign rnd_last  = rnd_last_q;
    assign prng_hold = prng_hold_q;

`ifdef PRNG_ARB_STATS_EN
    logic        drop, abort;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [7:0]  abort_cnt_q, abort_cnt_d;

    assign drop  = capture & full & ~pop;
    assign abort = (state_q == SERVE) & ~req[ptr_q];

    always_comb begin
        drop_cnt_d  = drop_cnt_q;
        abort_cnt_d = abort_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (abort && abort_cnt_q != 8'hFF) begin
            abort_cnt_d = abort_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            drop_cnt_q  <= '0;
            abort_cnt_q <= '0;
        end else begin
            drop_cnt_q  <= drop_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign drop_cnt  = drop_cnt_q;
    assign abort_cnt = abort_cnt_q;
`endif

endmodule

// File: tb/tb_prng_arbiter.sv
// Bench for prng_arbiter: directed scenarios plus random traffic, each cycle compared
// against a queue-based model of the arbiter.
`timescale 1ns/1ps
module tb_prng_arbiter;
    localparam int NR = 4;
    localparam int BL = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          res_n = 1'b0;
    logic [7:0]    prng_dout = '0;
    logic          prng_done = 1'b0;
    logic          prng_hold;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] gnt;
    logic [7:0]    rnd_data;
    logic          rnd_valid;
    logic          rnd_last;
`ifdef PRNG_ARB_STATS_EN
    logic [15:0]   drop_cnt;
    logic [7:0]    abort_cnt;
`endif

    always #5 clk = ~clk;

    prng_arbiter #(.NUM_REQ(NR), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .res_n(res_n), .prng_dout(prng_dout), .prng_done(prng_done),
        .prng_hold(prng_hold), .req(req), .gnt(gnt), .rnd_data(rnd_data),
        .rnd_valid(rnd_valid), .rnd_last(rnd_last)
`ifdef PRNG_ARB_STATS_EN
        , .drop_cnt(drop_cnt), .abort_cnt(abort_cnt)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: whole-byte queue, current owner (-1 = none), last winner, bytes in burst.
    logic [7:0]    m_q[$];
    int            m_owner, m_last, m_burst, m_drop, m_abort;
    bit            m_prev;
    logic [NR-1:0] e_gnt;
    logic [7:0]    e_data;
    bit            e_valid, e_last, e_hold;
    logic [NR-1:0] gnt_log[$];
    logic [NR-1:0] gnt_prev = '0;

    function automatic void model_reset();
        m_q.delete();
        m_owner = -1; m_last = NR - 1; m_burst = 0; m_drop = 0; m_abort = 0;
        m_prev = 0; e_gnt = '0; e_data = '0; e_valid = 0; e_last = 0; e_hold = 1;
    endfunction

    function automatic void model_step();
        int  size0, w;
        bit  popped, found;
        size0 = m_q.size();
        popped = 0; e_valid = 0; e_last = 0;
        if (m_owner < 0) begin
            if (req != '0) begin
                found = 0;
                for (int i = 1; i <= NR; i++) begin
                    w = (m_last + i) % NR;
                    if (!found && req[w]) begin
                        m_owner = w;
                        found = 1;
                    end
                end
                m_last = m_owner; m_burst = 0; e_gnt = NR'(1) << m_owner;
            end
        end else if (!req[m_owner]) begin
            m_owner = -1; e_gnt = '0; m_burst = 0;
            if (m_abort < 255) m_abort++;
        end else if (size0 > 0) begin
            e_data = m_q.pop_front(); popped = 1; e_valid = 1; m_burst++;
            if (m_burst == BL) begin
                e_last = 1; e_gnt = '0; m_owner = -1;
            end
        end
        if (prng_done && !m_prev) begin
            if (size0 < FD || popped) m_q.push_back(prng_dout);
            else if (m_drop < 65535) m_drop++;
        end
        m_prev = prng_done;
        e_hold = (m_q.size() == FD);
    endfunction

    task automatic compare_all();
        check("gnt", gnt, e_gnt);
        check("rnd_valid", rnd_valid, e_valid);
        check("rnd_last", rnd_last, e_last);
        check("rnd_data", rnd_data, e_data);
        check("prng_hold", prng_hold, e_hold);
`ifdef PRNG_ARB_STATS_EN
        check("drop_cnt", drop_cnt, m_drop);
        check("abort_cnt", abort_cnt, m_abort);
`endif
        if (gnt != '0 && gnt_prev == '0) gnt_log.push_back(gnt);
        gnt_prev = gnt;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!res_n) model_reset();
        else model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic pulse(input logic [7:0] b);
        prng_dout = b; prng_done = 1'b1;
        cycle();
        prng_done = 1'b0;
        cycle();
    endtask

    task automatic reset_now();
        #2 res_n = 1'b0;
        #1 model_reset();
        check("rst_gnt", gnt, 0);
        check("rst_valid", rnd_valid, 0);
        check("rst_last", rnd_last, 0);
        check("rst_data", rnd_data, 0);
        check("rst_hold", prng_hold, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int seen;
        model_reset();
        repeat (2) cycle();
        check("rst_hold_init", prng_hold, 1);
        check("rst_gnt_init", gnt, 0);
        res_n = 1'b1;
        cycle();
        check("hold_release", prng_hold, 0);

        // Single requester, four bytes in order.
        req = 4'b0001;
        cycle();
        check("t1_gnt", gnt, 4'b0001);
        pulse(8'h11); pulse(8'h22); pulse(8'h33); pulse(8'h44);
        repeat (3) cycle();
        req = '0;
        cycle();

        // All requesting: four full bursts, rotating from requester 1.
        gnt_log.delete();
        req = 4'b1111;
        for (int i = 0; i < 16; i++) pulse(8'(8'h60 + i));
        repeat (6) cycle();
        req = '0;
        repeat (2) cycle();
        check("t2_ngrants", (gnt_log.size() >= 4), 1);
        if (gnt_log.size() >= 4) begin
            check("t2_g0", gnt_log[0], 4'b0010);
            check("t2_g1", gnt_log[1], 4'b0100);
            check("t2_g2", gnt_log[2], 4'b1000);
            check("t2_g3", gnt_log[3], 4'b0001);
        end

        // Fill to full, drop one, release hold with a pop.
        pulse(8'hA0); pulse(8'hA1); pulse(8'hA2); pulse(8'hA3);
        check("t3_hold_full", prng_hold, 1);
        pulse(8'hA4);
`ifdef PRNG_ARB_STATS_EN
        check("t3_drop1", drop_cnt, 1);
`endif
        req = 4'b0001;
        cycle();
        cycle();
        check("t3_pop_data", rnd_data, 8'hA0);
        check("t3_hold_pop", prng_hold, 0);
        repeat (6) cycle();
        req = '0;
        cycle();

        // Abort after two bytes; leftovers go to the next requester.
        pulse(8'hB0); pulse(8'hB1); pulse(8'hB2); pulse(8'hB3);
        req = 4'b0100;
        seen = 0;
        for (int k = 0; k < 20 && seen < 2; k++) begin
            cycle();
            if (rnd_valid) seen++;
        end
        check("t4_two_bytes", seen, 2);
        req = '0;
        cycle();
        check("t4_abort_gnt", gnt, 0);
        check("t4_abort_last", rnd_last, 0);
        req = 4'b1000;
        cycle();
        check("t4_gnt3", gnt, 4'b1000);
        cycle();
        check("t4_carry0", rnd_data, 8'hB2);
        cycle();
        check("t4_carry1", rnd_data, 8'hB3);
        pulse(8'hB4); pulse(8'hB5);
        repeat (2) cycle();
        req = '0;
        cycle();

        // Level-high done captures once.
        prng_dout = 8'h5A; prng_done = 1'b1;
        repeat (3) cycle();
        prng_done = 1'b0;
        cycle();
        req = 4'b0010;
        cycle();
        cycle();
        check("t5_data", rnd_data, 8'h5A);
        check("t5_valid", rnd_valid, 1);
        cycle();
        check("t5_single", rnd_valid, 0);
        req = '0;
        repeat (2) cycle();

        // Asynchronous reset mid-burst, then requester 0 wins first.
        req = 4'b0001;
        pulse(8'hC1);
        check("t6_first", rnd_valid, 1);
        pulse(8'hC2);
        reset_now();
        cycle();
        req = 4'b1111;
        res_n = 1'b1;
        cycle();
        check("t6_rr", gnt, 4'b0001);
        req = '0;
        repeat (2) cycle();

        // Random traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 7) == 0) req = NR'($urandom);
            prng_done = 1'($urandom_range(0, 1));
            prng_dout = 8'($urandom);
            cycle();
            if ($urandom_range(0, 399) == 0) begin
                reset_now();
                cycle();
                res_n = 1'b1;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
